strobe_scheduler: RTL and testbench
===================================

# strobe_scheduler

Multi-channel strobe scheduler that shares one strobe output between CHANNELS level-signal requesters. Each input rising edge becomes a pending request. Pending requests are granted in round-robin order as single-cycle strobes tagged with the channel index, with a guaranteed minimum low gap between strobes. It sits between asynchronous-rate event sources (already synchronous to clk) and a single downstream strobe consumer.

## Interface
- CHANNELS, 4: number of requesters; legal range 2..8.
- IDX_W, 2: width of strobe_idx; must satisfy CHANNELS <= 2**IDX_W.
- GAP, 3: minimum number of strobe-low cycles between consecutive strobes; legal range 1..255.
- clk  in  1  single clock; all logic is rising-edge.
- resetn  in  1  reset, asynchronous assert, active-low.
- signal  in  CHANNELS  per-channel level inputs, synchronous to clk.
- enable  in  1  global grant enable; edges are still captured while low.
- strobe  out  1  one-cycle grant pulse.
- strobe_idx  out  IDX_W  channel granted; valid while strobe=1 and held until the next grant.
- pending  out  CHANNELS  registered pending-request flags.
- overflow  out  CHANNELS  one-cycle pulse: an edge was lost on that channel.
- busy  out  1  high whenever state != IDLE.

## Operation
- Edge detect: signal_d is the registered copy of signal. rise[i] = signal[i] & ~signal_d[i]. A level held high yields exactly one edge.
- Pending[i]:
  - Set on rise[i].
  - Cleared at the edge where channel i is granted.
  - If rise[i] and a grant of i occur in the same cycle, pending[i] stays 1, because the new event is kept.
- Overflow[i] = 1 for one cycle when rise[i] occurs, pending[i] is already 1, and i is not granted that cycle. The lost event is not counted.
- Round-robin: search pending starting at (last+1) mod CHANNELS, wrapping. The first set bit wins. last updates to the winner at grant.
- FSM states IDLE, FIRE, HOLD, with 8-bit down-counter cnt:
  - IDLE: if enable and pending != 0, grant the winner and go to FIRE. Otherwise stay in IDLE.
  - FIRE: strobe=1 for exactly this cycle. If GAP=1, go to IDLE. Else load cnt=GAP-2 and go to HOLD.
  - HOLD: if cnt=0, go to IDLE. Else cnt decrements.
- Grant is registered: at the IDLE→FIRE edge, strobe<=1, strobe_idx<=winner, pending[winner] cleared, last<=winner.
- Strobe deasserts on the FIRE exit edge.
- Deasserting enable never truncates FIRE/HOLD; it only blocks the next IDLE→FIRE transition.

## Timing
- Reset (async, resetn=0) forces:
  - strobe=0, strobe_idx=0, pending=0, overflow=0, busy=0.
  - state=IDLE, cnt=0.
  - last=CHANNELS-1, so channel 0 has first priority.
  - signal_d=0.
- Consequence of signal_d=0: an input already high at reset release is treated as a rising edge in the first cycle.
- Latency, with idle FSM and enable=1:
  - signal[i] is first sampled high at edge k, so pending[i]=1 after edge k.
  - strobe=1 after edge k+1, for one cycle.
  - pending[i] returns to 0 after edge k+1.
- Throughput: strobe at cycle t, then strobe=0 for cycles t+1..t+GAP. The earliest next strobe is t+GAP+1.
- Per grant, busy is high for GAP cycles: the FIRE cycle plus GAP-1 HOLD cycles.
- Overflow pulses in the cycle after the lost edge is sampled, i.e. aligned with the pending update.
- Reset mid-FIRE/HOLD: outputs clear immediately and asynchronously. All pending requests are discarded.

## Test plan
- Single event (GAP=3, CHANNELS=4):
  - Stimulus: signal[0] 0→1 sampled at edge k.
  - Required: pending=4'b0001 after k; strobe=1 with strobe_idx=0 after k+1 for one cycle; busy=1 for 3 cycles; no further strobe while signal[0] stays high.
- Simultaneous edges:
  - Stimulus: signal 4'b0000→4'b1101 in one cycle.
  - Required: strobes with idx 0, 2, 3 at cycles t, t+4, t+8; pending drains 1101→1100→1000→0000.
- Round-robin fairness:
  - Stimulus: after a grant to channel 1, both ch1 and ch2 pending.
  - Required: next grant idx=2, then idx=1. With ch3 and ch0 pending and last=3, grant order is 0 then 3.
- Overflow with enable=0:
  - Stimulus: two rising edges on signal[1] five cycles apart.
  - Required: no strobe; pending[1]=1; overflow[1] one-cycle pulse on the second edge only. Then enable=1 yields exactly one strobe, idx=1.
- Same-cycle grant and new edge:
  - Stimulus: ch2 is granted in the same cycle rise[2] occurs.
  - Required: pending[2] remains 1, overflow[2]=0, and a second strobe with idx=2 follows GAP+1 cycles later.
- Reset mid-operation:
  - Stimulus: resetn=0 during HOLD with pending=4'b0110.
  - Required: strobe, busy and pending read 0 immediately, without waiting for a clock. After release with signal[3] held high, a strobe with idx=3 appears 2 edges later.

Source files
------------

// File: rtl/strobe_scheduler.sv
// strobe_scheduler: shares one strobe output between CHANNELS level-signal
// requesters. Rising edges become pending requests. Pending requests are granted
// round-robin as single-cycle strobes tagged with the channel index. Consecutive
// strobes are separated by at least GAP strobe-low cycles.
module strobe_scheduler #(
    parameter int CHANNELS = 4,
    parameter int IDX_W    = 2,
    parameter int GAP      = 3
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [CHANNELS-1:0] signal,
    input  logic                enable,
    output logic                strobe,
    output logic [IDX_W-1:0]    strobe_idx,
    output logic [CHANNELS-1:0] pending,
    output logic [CHANNELS-1:0] overflow,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        HOLD
    } state_t;

    // HOLD lasts GAP-1 cycles, counting down to zero inclusive.
    localparam logic [7:0] HOLD_LOAD = (GAP > 1) ? 8'(GAP - 2) : 8'd0;

    state_t                state;
    state_t                state_next;
    logic [7:0]            cnt;
    logic [7:0]            cnt_next;
    logic [CHANNELS-1:0]   signal_d;
    logic [CHANNELS-1:0]   rise;
    logic [CHANNELS-1:0]   grant_mask;
    logic [IDX_W-1:0]      last;
    logic [IDX_W-1:0]      winner;
    logic                  grant;

    assign rise       = signal & ~signal_d;
    assign grant_mask = grant ? (CHANNELS'(1) << winner) : '0;
    assign strobe     = (state == FIRE);
    assign busy       = (state != IDLE);

    // Round-robin pick: the lowest pending channel above last wins; if none,
    // the lowest pending channel at or below last wins (wrap-around).
    always_comb begin
        winner = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (pending[i] && (i <= int'(last))) winner = IDX_W'(i);
        end
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (pending[i] && (i > int'(last))) winner = IDX_W'(i);
        end
    end

    // Next-state logic: grant from IDLE, one FIRE cycle, then the low gap.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a latch behind.
        state_next = state;
        cnt_next   = cnt;
        grant      = 1'b0;
        case (state)
            IDLE: begin
                if (enable && (|pending)) begin
                    grant      = 1'b1;
                    state_next = FIRE;
                end
            end
            FIRE: begin
                if (GAP == 1) begin
                    state_next = IDLE;
                end else begin
                    cnt_next   = HOLD_LOAD;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (cnt == 8'd0) state_next = IDLE;
                else             cnt_next   = cnt - 8'd1;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and gap counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Request bookkeeping: edge capture, pending flags, overflow, grant record.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            signal_d   <= '0;
            pending    <= '0;
            overflow   <= '0;
            strobe_idx <= '0;
            last       <= IDX_W'(CHANNELS - 1);
        end else begin
            signal_d <= signal;
            // A new edge on the channel being granted is kept as a fresh request.
            pending  <= (pending & ~grant_mask) | rise;
            overflow <= rise & pending & ~grant_mask;
            if (grant) begin
                strobe_idx <= winner;
                last       <= winner;
            end
        end
    end

endmodule

// File: tb/tb_strobe_scheduler.sv
// Bench for strobe_scheduler (CHANNELS=4, GAP=3): table vectors, directed
// corner-case sequences and random stimulus against a cycle-level model.
module tb_strobe_scheduler;

    localparam int CH  = 4;
    localparam int GAP = 3;

    logic          clk;
    logic          resetn;
    logic [CH-1:0] signal;
    logic          enable;
    logic          strobe;
    logic [1:0]    strobe_idx;
    logic [CH-1:0] pending;
    logic [CH-1:0] overflow;
    logic          busy;

    int total = 0;
    int bad   = 0;

    strobe_scheduler #(.CHANNELS(CH), .IDX_W(2), .GAP(GAP)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .signal     (signal),
        .enable     (enable),
        .strobe     (strobe),
        .strobe_idx (strobe_idx),
        .pending    (pending),
        .overflow   (overflow),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending set, round-robin pointer and a cooldown count of
    // busy cycles still to come after the current edge.
    logic [CH-1:0] m_pend;
    logic [CH-1:0] m_ovf;
    logic [CH-1:0] m_sig_d;
    int            m_last;
    int            m_cool;
    logic          m_strobe;
    int            m_idx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pend   = '0;
        m_ovf    = '0;
        m_sig_d  = '0;
        m_last   = CH - 1;
        m_cool   = 0;
        m_strobe = 1'b0;
        m_idx    = 0;
    endtask

    task automatic model_edge();
        logic [CH-1:0] rise;
        logic [CH-1:0] old_pend;
        int            granted;
        rise     = signal & ~m_sig_d;
        old_pend = m_pend;
        granted  = -1;
        if (m_cool == 0 && enable && old_pend != 0) begin
            for (int k = 1; k <= CH; k++) begin
                int c;
                c = (m_last + k) % CH;
                if (granted < 0 && old_pend[c]) granted = c;
            end
        end
        for (int c = 0; c < CH; c++) begin
            m_ovf[c]  = rise[c] && old_pend[c] && (c != granted);
            m_pend[c] = (old_pend[c] && (c != granted)) || rise[c];
        end
        if (granted >= 0) begin
            m_strobe = 1'b1;
            m_idx    = granted;
            m_last   = granted;
            m_cool   = GAP;
        end else begin
            m_strobe = 1'b0;
            if (m_cool > 0) m_cool--;
        end
        m_sig_d = signal;
    endtask

    // One clock: advance the model at the edge, compare everything 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (!resetn) model_reset();
        else         model_edge();
        #1;
        check("model", {20'd0, strobe, strobe_idx, pending, overflow, busy},
              {20'd0, m_strobe, 2'(m_idx), m_pend, m_ovf, (m_cool > 0)});
    endtask

    task automatic wait_strobe(input int exp_idx, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!strobe && cycles < 20);
        check("strobe_seen", {31'd0, strobe}, 32'd1);
        check("strobe_idx", {30'd0, strobe_idx}, exp_idx);
    endtask

    typedef struct {
        logic [CH-1:0] sig;
        logic          en;
        logic          s;
        logic [1:0]    idx;
        logic [CH-1:0] pend;
        logic          bsy;
    } vec_t;

    vec_t vecs[22];

    initial begin
        int cyc;
        int nstr;
        int lidx;

        // Simultaneous edges from reset (channel 0 first), then a single event.
        vecs[0]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0};
        vecs[1]  = '{4'b1101, 1'b1, 1'b0, 2'd0, 4'b1101, 1'b0};
        vecs[2]  = '{4'b1101, 1'b1, 1'b1, 2'd0, 4'b1100, 1'b1};
        vecs[3]  = '{4'b1101, 1'b1, 1'b0, 2'd0, 4'b1100, 1'b1};
        vecs[4]  = '{4'b1101, 1'b1, 1'b0, 2'd0, 4'b1100, 1'b1};
        vecs[5]  = '{4'b1101, 1'b1, 1'b0, 2'd0, 4'b1100, 1'b0};
        vecs[6]  = '{4'b1101, 1'b1, 1'b1, 2'd2, 4'b1000, 1'b1};
        vecs[7]  = '{4'b1101, 1'b1, 1'b0, 2'd2, 4'b1000, 1'b1};
        vecs[8]  = '{4'b1101, 1'b1, 1'b0, 2'd2, 4'b1000, 1'b1};
        vecs[9]  = '{4'b1101, 1'b1, 1'b0, 2'd2, 4'b1000, 1'b0};
        vecs[10] = '{4'b1101, 1'b1, 1'b1, 2'd3, 4'b0000, 1'b1};
        vecs[11] = '{4'b1101, 1'b1, 1'b0, 2'd3, 4'b0000, 1'b1};
        vecs[12] = '{4'b1101, 1'b1, 1'b0, 2'd3, 4'b0000, 1'b1};
        vecs[13] = '{4'b1101, 1'b1, 1'b0, 2'd3, 4'b0000, 1'b0};
        vecs[14] = '{4'b0000, 1'b1, 1'b0, 2'd3, 4'b0000, 1'b0};
        vecs[15] = '{4'b0001, 1'b1, 1'b0, 2'd3, 4'b0001, 1'b0};
        vecs[16] = '{4'b0001, 1'b1, 1'b1, 2'd0, 4'b0000, 1'b1};
        vecs[17] = '{4'b0001, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b1};
        vecs[18] = '{4'b0001, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b1};
        vecs[19] = '{4'b0001, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0};
        vecs[20] = '{4'b0001, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0};
        vecs[21] = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0};

        resetn = 1'b0;
        signal = '0;
        enable = 1'b1;
        model_reset();
        tick();
        tick();
        check("reset_outputs", {20'd0, strobe, strobe_idx, pending, overflow, busy}, 32'd0);
        resetn = 1'b1;

        // Table vectors.
        for (int i = 0; i < 22; i++) begin
            signal = vecs[i].sig;
            enable = vecs[i].en;
            tick();
            check($sformatf("vec%0d", i), {23'd0, strobe, strobe_idx, pending, busy, overflow != 0},
                  {23'd0, vecs[i].s, vecs[i].idx, vecs[i].pend, vecs[i].bsy, 1'b0});
        end

        // Round-robin: grant ch1, then ch1+ch2 pending -> 2 then 1.
        signal = 4'b0010; tick();
        signal = 4'b0000; tick();
        check("rr_first_ch1", {30'd0, strobe, strobe_idx[0]}, 32'b11);
        signal = 4'b0110; tick();
        wait_strobe(2, cyc);
        wait_strobe(1, cyc);
        // Move last to 3, then ch0+ch3 pending -> 0 then 3.
        signal = 4'b0000; tick();
        signal = 4'b1000;
        wait_strobe(3, cyc);
        signal = 4'b0000; tick();
        signal = 4'b1001; tick();
        wait_strobe(0, cyc);
        wait_strobe(3, cyc);
        signal = 4'b0000;
        repeat (4) tick();

        // Overflow while enable is low: two edges on ch1 five cycles apart.
        enable = 1'b0;
        signal = 4'b0010; tick();
        check("ovf_first_pend", {28'd0, pending}, 32'b0010);
        check("ovf_first_none", {28'd0, overflow}, 32'd0);
        signal = 4'b0000;
        repeat (4) tick();
        signal = 4'b0010; tick();
        check("ovf_pulse", {28'd0, overflow}, 32'b0010);
        check("ovf_no_strobe", {31'd0, strobe}, 32'd0);
        tick();
        check("ovf_one_cycle", {28'd0, overflow}, 32'd0);
        enable = 1'b1;
        nstr = 0;
        lidx = -1;
        repeat (10) begin
            tick();
            if (strobe) begin
                nstr++;
                lidx = strobe_idx;
            end
        end
        check("ovf_strobe_count", nstr, 32'd1);
        check("ovf_strobe_idx", lidx, 32'd1);

        // Same-cycle grant of ch2 and a new rising edge on ch2.
        enable = 1'b0;
        signal = 4'b0100; tick();
        signal = 4'b0000; tick();
        enable = 1'b1;
        signal = 4'b0100; tick();
        check("same_grant", {29'd0, strobe, strobe_idx}, 32'b110);
        check("same_pend2", {31'd0, pending[2]}, 32'd1);
        check("same_ovf2", {31'd0, overflow[2]}, 32'd0);
        wait_strobe(2, cyc);
        check("same_spacing", cyc, GAP + 1);

        // Reset during HOLD with pending 0110.
        signal = 4'b0000;
        repeat (3) tick();
        signal = 4'b0111; tick();
        tick();
        tick();
        check("hold_state", {27'd0, busy, pending}, {27'd0, 1'b1, 4'b0110});
        resetn = 1'b0;
        #1;
        check("async_reset", {26'd0, strobe, busy, pending}, 32'd0);
        model_reset();
        tick();
        signal = 4'b1000;
        resetn = 1'b1;
        tick();
        check("post_reset_pend", {28'd0, pending}, 32'b1000);
        tick();
        check("post_reset_strobe", {29'd0, strobe, strobe_idx}, 32'b111);

        // Random stimulus against the model.
        for (int n = 0; n < 400; n++) begin
            for (int b = 0; b < CH; b++) begin
                if ($urandom_range(3) == 0) signal[b] = ~signal[b];
            end
            enable = ($urandom_range(7) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
